// File: rtl/qc_pipelined_inverse_rotator.sv
// Pipelined inverse QC-LDPC rotator: left-rotates the low in_z bits of a padded sub-block,
// with valid/ready flow control, tag pass-through, null-block bypass and per-beat error flag.
module qc_pipelined_inverse_rotator #(
    parameter  int MAXZ                  = 81,
    parameter  int PIPE_STAGES_PER_CYCLE = 1,
    parameter  int TAGW                  = 8,
    localparam int SW                    = $clog2(MAXZ)
) (
    input  logic            CLK,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [MAXZ-1:0] in_data,
    input  logic [SW-1:0]   in_shift,
    input  logic [SW:0]     in_z,
    input  logic            in_null,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [MAXZ-1:0] out_data,
    output logic [TAGW-1:0] out_tag,
    output logic            out_err
);

    localparam int Lpc       = (PIPE_STAGES_PER_CYCLE < 1) ? 1 : PIPE_STAGES_PER_CYCLE;
    localparam int NumStages = (SW + Lpc - 1) / Lpc;

    // Valid/ready contract: a beat moves on a rising edge when valid && ready. The whole
    // pipe advances together whenever the output register is empty or being drained, so
    // in_ready is that same advance term and a stalled output holds all of its fields.

    // Left rotation by amt confined to bits [z-1:0]; bits at or above z come out zero.
    function automatic logic [MAXZ-1:0] rotl_level(input logic [MAXZ-1:0] x,
                                                   input int amt,
                                                   input logic [SW:0] z);
        logic [MAXZ-1:0] r;
        logic [SW-1:0]   sel;
        int              idx;
        r = '0;
        for (int j = 0; j < MAXZ; j++) begin
            if (j < int'(z)) begin
                idx = j - amt;
                if (idx < 0) begin
                    idx = idx + int'(z);
                end
                sel = idx[SW-1:0];
                if (idx >= 0 && idx < MAXZ) begin
                    r[j] = x[sel];
                end
            end
        end
        return r;
    endfunction

    // Applies the Lpc rotation levels starting at level 'base'.
    function automatic logic [MAXZ-1:0] apply_levels(input logic [MAXZ-1:0] x,
                                                     input logic [SW-1:0] shift,
                                                     input logic [SW:0] z,
                                                     input int base);
        logic [MAXZ-1:0] r;
        logic [SW-1:0]   sh;
        r  = x;
        sh = shift >> base;
        for (int l = 0; l < Lpc; l++) begin
            if (sh[0]) begin
                r = rotl_level(r, 1 << (base + l), z);
            end
            sh = sh >> 1;
        end
        return r;
    endfunction

    logic [MAXZ-1:0] data_q  [NumStages];
    logic [MAXZ-1:0] data_d  [NumStages];
    logic [SW-1:0]   shift_q [NumStages];
    logic [SW-1:0]   shift_d [NumStages];
    logic [SW:0]     z_q     [NumStages];
    logic [SW:0]     z_d     [NumStages];
    logic            null_q  [NumStages];
    logic            null_d  [NumStages];
    logic            err_q   [NumStages];
    logic            err_d   [NumStages];
    logic [TAGW-1:0] tag_q   [NumStages];
    logic [TAGW-1:0] tag_d   [NumStages];
    logic            vld_q   [NumStages];
    logic            vld_d   [NumStages];

    logic [MAXZ-1:0] src_data  [NumStages];
    logic [SW-1:0]   src_shift [NumStages];
    logic [SW:0]     src_z     [NumStages];
    logic            src_null  [NumStages];
    logic            src_err   [NumStages];
    logic [TAGW-1:0] src_tag   [NumStages];
    logic            src_vld   [NumStages];

    logic            advance;
    logic            in_err;
    logic [MAXZ-1:0] in_masked;

    assign out_valid = vld_q[NumStages-1];
    assign out_data  = data_q[NumStages-1];
    assign out_tag   = tag_q[NumStages-1];
    assign out_err   = err_q[NumStages-1];
    assign advance   = out_ready || !out_valid;
    assign in_ready  = advance;

    // Legality is judged once at the input; later stages only carry the flag.
    always_comb begin
        in_err = (in_z == '0) || (in_z > (SW+1)'(MAXZ)) || ({1'b0, in_shift} >= in_z);
        in_masked = '0;
        for (int j = 0; j < MAXZ; j++) begin
            if (j < int'(in_z)) begin
                in_masked[j] = in_data[j];
            end
        end
    end

    always_comb begin
        src_data[0]  = in_masked;
        src_shift[0] = in_shift;
        src_z[0]     = in_z;
        src_null[0]  = in_null;
        src_err[0]   = in_err;
        src_tag[0]   = in_tag;
        src_vld[0]   = in_valid;
        for (int k = 1; k < NumStages; k++) begin
            src_data[k]  = data_q[k-1];
            src_shift[k] = shift_q[k-1];
            src_z[k]     = z_q[k-1];
            src_null[k]  = null_q[k-1];
            src_err[k]   = err_q[k-1];
            src_tag[k]   = tag_q[k-1];
            src_vld[k]   = vld_q[k-1];
        end
    end

    // Bubbles, error beats and null beats carry zero data so the output reads zero for them.
    always_comb begin
        for (int k = 0; k < NumStages; k++) begin
            data_d[k]  = '0;
            shift_d[k] = src_shift[k];
            z_d[k]     = src_z[k];
            null_d[k]  = src_vld[k] && src_null[k];
            err_d[k]   = src_vld[k] && src_err[k];
            tag_d[k]   = src_vld[k] ? src_tag[k] : '0;
            vld_d[k]   = src_vld[k];
            if (src_vld[k] && !src_err[k] && !src_null[k]) begin
                data_d[k] = apply_levels(src_data[k], src_shift[k], src_z[k], k * Lpc);
            end
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NumStages; k++) begin
                data_q[k]  <= '0;
                shift_q[k] <= '0;
                z_q[k]     <= '0;
                null_q[k]  <= 1'b0;
                err_q[k]   <= 1'b0;
                tag_q[k]   <= '0;
                vld_q[k]   <= 1'b0;
            end
        end else if (advance) begin
            for (int k = 0; k < NumStages; k++) begin
                data_q[k]  <= data_d[k];
                shift_q[k] <= shift_d[k];
                z_q[k]     <= z_d[k];
                null_q[k]  <= null_d[k];
                err_q[k]   <= err_d[k];
                tag_q[k]   <= tag_d[k];
                vld_q[k]   <= vld_d[k];
            end
        end
    end

endmodule

// File: doc/qc_pipelined_inverse_rotator.md
Name: qc_pipelined_inverse_rotator

Overview:
- Undoes the cyclic right-rotation that pipelinedCircularShifter applies to QC-LDPC sub-blocks.
- Rotates each Z-bit sub-block left by shift_val, modulo a runtime lifting size z_size (z_size <= MAXZ).
- Data is zero-padded to MAXZ.
- Sits on the decoder/check-node side; adds valid/ready flow control, a pass-through tag, a null-block bypass for base-matrix "-1" entries, and per-beat error reporting.

Parameters:
- MAXZ, 81: padded data width; largest supported lifting size.
- PIPE_STAGES_PER_CYCLE, 1: rotation levels per register stage; must be >= 1.
- TAGW, 8: width of the sideband tag carried alongside data.
- Derived, not overridable: SW = $clog2(MAXZ); NumStages = ceil(SW / PIPE_STAGES_PER_CYCLE).

Ports:
- CLK  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_data  in  MAXZ  sub-block; bits [MAXZ-1:z_size] ignored (treated as 0).
- in_shift  in  SW  left-rotation amount.
- in_z  in  SW+1  lifting size for this beat.
- in_null  in  1  base-matrix -1 entry; output all zeros.
- in_tag  in  TAGW  sideband, passed through unchanged.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  MAXZ  rotated sub-block.
- out_tag  out  TAGW  tag of the output beat.
- out_err  out  1  beat had an illegal shift or size.

Behaviour:
- Function, for a legal beat: out_data[j] = in_data[(j - in_shift) mod in_z] for j < in_z; out_data[j] = 0 for j >= in_z.
- Decomposition: stage level i rotates left by 2^i within in_z when in_shift[i] = 1. Each stage rotates a value already confined to the low in_z bits.
- Pipelining: every register stage carries data, residual shift bits, z, null, err, tag and a valid bit. Levels are grouped PIPE_STAGES_PER_CYCLE per register stage.
- Latency: exactly NumStages cycles from input handshake to out_valid when never stalled (MAXZ=81, PIPE_STAGES_PER_CYCLE=1 gives 7). Throughput is 1 beat per cycle.
- Flow control: global advance = out_ready || !out_valid.
  - All stages shift together when advance = 1 and hold when advance = 0.
  - in_ready = advance; it is combinational from out_ready and the out_valid register.
  - Bubbles are not collapsed.
  - While out_valid = 1 and out_ready = 0, out_data, out_tag and out_err are stable.
- Input acceptance: a beat is accepted only when in_valid && in_ready. When in_valid = 0 and advance = 1, a bubble (valid = 0) enters stage 0. No input is registered while advance = 0.
- Error: err = (in_z == 0) || (in_z > MAXZ) || (in_shift >= in_z), evaluated at input.
  - An err beat produces out_data = 0 and out_err = 1; the tag is still passed.
  - Err takes precedence over in_null.
- Null: in_null = 1 with no err produces out_data = 0, out_err = 0. in_shift is ignored apart from the err check.
- Boundaries:
  - in_shift = 0: output equals input masked to in_z bits.
  - in_z = MAXZ: plain modulo-MAXZ rotation; round-trip with pipelinedCircularShifter is identity.
  - in_z = 1: any shift other than 0 sets err.
  - in_shift = in_z - 1 is legal.
- Reset:
  - Asynchronously clears all stage valid bits, data, tags and err to 0. out_valid = 0, out_data = 0, out_tag = 0, out_err = 0.
  - in_ready = 1 while rst is asserted and after release.
  - Beats in flight are discarded with no partial output.
- Invalid stage contents are don't-care internally, but out_data must read 0 whenever out_valid = 0 after reset until the first valid beat.

Test Plan:
- Defaults, in_z=8, in_data=0x01, in_shift=3, out_ready=1 -> out_valid on cycle 7 after accept, out_data=0x08, out_err=0, out_tag matches.
- in_z=8, in_data=0x80, in_shift=1 -> out_data=0x01. Same with in_data bit 40 also set -> still 0x01, because the upper bits are masked.
- Round-trip: 200 random MAXZ-bit words through pipelinedCircularShifter(shift s), then through this block with in_z=81, in_shift=s -> output equals original for every word, in order.
- Errors and null: in_z=8, in_shift=8 -> out_data=0, out_err=1. in_z=0 -> out_err=1. in_z=82 -> out_err=1. in_null=1, in_z=16, in_shift=5, data=0xFFFF -> out_data=0, out_err=0.
- Backpressure: stream 20 tagged beats at full rate with out_ready toggling randomly -> no beat lost or duplicated, tags 0..19 in order, output held stable while stalled, in_ready=0 exactly when out_valid && !out_ready.
- Reset mid-stream: assert rst with 5 beats in flight -> out_valid=0 immediately (asynchronous). After release no stale beat emerges, and a new beat emerges with latency 7.
